// File: rtl/apb_rr_scheduler_pkg.sv
// Shared types and constants for the APB round-robin scheduler.
// State encoding matches the legacy IDLE=0, SETUP=1, ACCESS=2, DONE=3 values.
package apb_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int APB_STRB_W = 4;

   // READ_WRITE encoding seen by the APB master
   localparam logic APB_READ  = 1'b1;
   localparam logic APB_WRITE = 1'b0;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_rr_scheduler_if.sv
// Requester-side and APB-master-side signals of the scheduler, bundled as one interface.
// The slave modport is the scheduler's view; master is the view of its surroundings.
interface apb_rr_scheduler_if
   import apb_rr_scheduler_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = 33,
   parameter int DW   = 32
);

   logic [NREQ-1:0]            req;
   logic [NREQ-1:0]            req_write;
   logic [NREQ*AW-1:0]         req_addr;
   logic [NREQ*DW-1:0]         req_wdata;
   logic [NREQ*APB_STRB_W-1:0] req_strb;
   logic [NREQ-1:0]            gnt;
   logic [NREQ-1:0]            done;
   logic [DW-1:0]              rsp_rdata;
   logic                       rsp_err;

   logic                       transfer;
   logic                       READ_WRITE;
   logic [AW-1:0]              get_w_paddr;
   logic [AW-1:0]              get_r_paddr;
   logic [DW-1:0]              get_w_data_in;
   logic [APB_STRB_W-1:0]      PSTRB;
   logic                       PENABLE;
   logic                       PREADY;
   logic                       PSLVERR;
   logic [AW-1:0]              send_r_out;

   modport slave (
      input  req, req_write, req_addr, req_wdata, req_strb,
      input  PENABLE, PREADY, PSLVERR, send_r_out,
      output gnt, done, rsp_rdata, rsp_err,
      output transfer, READ_WRITE, get_w_paddr, get_r_paddr, get_w_data_in, PSTRB
   );

   modport master (
      output req, req_write, req_addr, req_wdata, req_strb,
      output PENABLE, PREADY, PSLVERR, send_r_out,
      input  gnt, done, rsp_rdata, rsp_err,
      input  transfer, READ_WRITE, get_w_paddr, get_r_paddr, get_w_data_in, PSTRB
   );

endinterface

// File: rtl/apb_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: first pending request at or after ptr_i, wrapping.
module rr_pick
   import apb_rr_scheduler_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            valid_o
);

   int unsigned cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand     = (32'(ptr_i) + off) % NREQ;
         cand_idx = IW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o         = 1'b1;
            idx_o           = cand_idx;
            gnt_o[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin scheduler sharing one APB master among NREQ requesters.
// Latches the winner's command, holds it through SETUP/ACCESS, returns status in DONE.
module apb_rr_scheduler
   import apb_rr_scheduler_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int AW      = 33,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input logic                PCLK,
   input logic                PRESETn,
   apb_rr_scheduler_if.slave  bus
);

   localparam int IW = idx_w(NREQ);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                  write_q, write_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [APB_STRB_W-1:0] strb_q, strb_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [NREQ-1:0]       pick_gnt;
   logic [IW-1:0]         pick_idx;
   logic                  pick_valid;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_i   (bus.req),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Only the low DW bits of the master's read bus carry data
   generate
      if (AW > DW) begin : g_rdata_hi
         logic unused_rdata_hi;
         assign unused_rdata_hi = ^{bus.send_r_out[AW-1:DW], pick_gnt};
      end else begin : g_rdata_fit
         logic unused_pick_gnt;
         assign unused_pick_gnt = ^pick_gnt;
      end
   endgenerate

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         timer_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         timer_q  <= timer_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      timer_d  = timer_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               idx_d   = pick_idx;
               write_d = bus.req_write[pick_idx];
               addr_d  = bus.req_addr[32'(pick_idx) * AW +: AW];
               wdata_d = bus.req_wdata[32'(pick_idx) * DW +: DW];
               strb_d  = bus.req_strb[32'(pick_idx) * APB_STRB_W +: APB_STRB_W];
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            timer_d = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Completion wins over a timeout landing in the same cycle
            if (bus.PENABLE && bus.PREADY) begin
               if (!write_q) begin
                  rdata_d = bus.send_r_out[DW-1:0];
               end
               err_d   = bus.PSLVERR;
               state_d = ST_DONE;
            end else if (timer_q == TMAX) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            rr_ptr_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.transfer      = 1'b0;
      bus.READ_WRITE    = 1'b0;
      bus.get_w_paddr   = '0;
      bus.get_r_paddr   = '0;
      bus.get_w_data_in = '0;
      bus.PSTRB         = '0;
      bus.gnt           = '0;
      bus.done          = '0;
      if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
         bus.transfer    = 1'b1;
         bus.READ_WRITE  = write_q ? APB_WRITE : APB_READ;
         bus.get_w_paddr = addr_q;
         bus.get_r_paddr = addr_q;
         if (write_q) begin
            bus.get_w_data_in = wdata_q;
            bus.PSTRB         = strb_q;
         end
      end
      if (state_q != ST_IDLE) begin
         bus.gnt[idx_q] = 1'b1;
      end
      if (state_q == ST_DONE) begin
         bus.done[idx_q] = 1'b1;
      end
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Directed bench for apb_rr_scheduler with a minimal APB master model driving PENABLE.
module tb_apb_rr_scheduler;
   import apb_rr_scheduler_pkg::*;

   localparam int NREQ    = 2;
   localparam int AW      = 33;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic PCLK;
   logic PRESETn;
   int   n_vec;
   int   n_miss;

   apb_rr_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   apb_rr_scheduler #(
      .NREQ    (NREQ),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Master model: PENABLE follows the cycle after transfer rises, drops on completion
   always @(posedge PCLK) begin
      if (!PRESETn) bus.PENABLE <= 1'b0;
      else          bus.PENABLE <= bus.transfer && !(bus.PENABLE && bus.PREADY);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
      bus.req_write[i]           = wr;
      bus.req_addr[i*AW +: AW]   = a;
      bus.req_wdata[i*DW +: DW]  = d;
      bus.req_strb[i*4 +: 4]     = s;
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      bus.req = '0;
      tick();
      tick();
      PRESETn = 1'b1;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      bus.req        = '0;
      bus.req_write  = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_strb   = '0;
      bus.PREADY     = 1'b1;
      bus.PSLVERR    = 1'b0;
      bus.send_r_out = '0;
      PRESETn        = 1'b0;

      do_reset();
      check_eq("rst_transfer", bus.transfer, 0);
      check_eq("rst_gnt", bus.gnt, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_err", bus.rsp_err, 0);
      check_eq("rst_rdata", bus.rsp_rdata, 0);

      // Single write from requester 0
      set_cmd(0, 1'b1, 33'h4, 32'hA5A5_0001, 4'hF);
      bus.req = 2'b01;
      tick();
      check_eq("wr_setup_transfer", bus.transfer, 1);
      check_eq("wr_setup_gnt", bus.gnt, 2'b01);
      check_eq("wr_rw", bus.READ_WRITE, 0);
      check_eq("wr_waddr", bus.get_w_paddr, 33'h4);
      check_eq("wr_raddr", bus.get_r_paddr, 33'h4);
      check_eq("wr_wdata", bus.get_w_data_in, 32'hA5A5_0001);
      check_eq("wr_strb", bus.PSTRB, 4'hF);
      bus.req = 2'b00;
      set_cmd(0, 1'b0, 33'h1FF, 32'h0, 4'h0);
      tick();
      check_eq("wr_access_transfer", bus.transfer, 1);
      check_eq("wr_access_addr", bus.get_w_paddr, 33'h4);
      check_eq("wr_access_done", bus.done, 0);
      tick();
      check_eq("wr_done", bus.done, 2'b01);
      check_eq("wr_done_transfer", bus.transfer, 0);
      check_eq("wr_done_err", bus.rsp_err, 0);
      tick();
      check_eq("wr_idle_done", bus.done, 0);
      check_eq("wr_idle_gnt", bus.gnt, 0);

      // Single read from requester 1; upper bit of send_r_out must be discarded
      set_cmd(1, 1'b0, 33'h0, 32'h1111_2222, 4'hF);
      bus.send_r_out = 33'h1_0000_00FF;
      bus.req = 2'b10;
      tick();
      check_eq("rd_gnt", bus.gnt, 2'b10);
      check_eq("rd_rw", bus.READ_WRITE, 1);
      check_eq("rd_strb", bus.PSTRB, 0);
      check_eq("rd_wdata", bus.get_w_data_in, 0);
      bus.req = 2'b00;
      tick();
      tick();
      check_eq("rd_done", bus.done, 2'b10);
      check_eq("rd_rdata", bus.rsp_rdata, 32'h0000_00FF);
      check_eq("rd_err", bus.rsp_err, 0);
      tick();

      // Contention from reset: grants alternate 0,1,0,1 with one IDLE cycle between
      do_reset();
      set_cmd(0, 1'b1, 33'h100, 32'hAAAA_0000, 4'h3);
      set_cmd(1, 1'b1, 33'h200, 32'hBBBB_0000, 4'hC);
      bus.req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("rr_gnt", bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         check_eq("rr_addr", bus.get_w_paddr, (k % 2 == 0) ? 33'h100 : 33'h200);
         tick();
         tick();
         check_eq("rr_done", bus.done, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check_eq("rr_idle_transfer", bus.transfer, 0);
         check_eq("rr_idle_gnt", bus.gnt, 0);
      end
      bus.req = 2'b00;
      tick();

      // Wait states: PREADY low for 5 ACCESS cycles (rr_ptr=0)
      set_cmd(0, 1'b1, 33'h8, 32'h1234_5678, 4'hF);
      bus.req = 2'b01;
      tick();
      bus.req = 2'b00;
      bus.PREADY = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("ws_transfer", bus.transfer, 1);
         check_eq("ws_addr", bus.get_w_paddr, 33'h8);
         check_eq("ws_wdata", bus.get_w_data_in, 32'h1234_5678);
         check_eq("ws_done", bus.done, 0);
         tick();
      end
      bus.PREADY = 1'b1;
      check_eq("ws_last_transfer", bus.transfer, 1);
      tick();
      check_eq("ws_done_pulse", bus.done, 2'b01);
      check_eq("ws_err", bus.rsp_err, 0);
      tick();

      // Reset mid-ACCESS (rr_ptr=1 beforehand, must return to 0)
      set_cmd(1, 1'b1, 33'h30, 32'hCAFE_0000, 4'hF);
      bus.req = 2'b10;
      bus.PREADY = 1'b0;
      tick();
      tick();
      tick();
      check_eq("mr_pre_transfer", bus.transfer, 1);
      PRESETn = 1'b0;
      bus.req = 2'b00;
      tick();
      check_eq("mr_transfer", bus.transfer, 0);
      check_eq("mr_gnt", bus.gnt, 0);
      check_eq("mr_done", bus.done, 0);
      PRESETn = 1'b1;
      tick();
      check_eq("mr_done_after", bus.done, 0);
      bus.PREADY = 1'b1;
      bus.req = 2'b11;
      tick();
      check_eq("mr_ptr_gnt", bus.gnt, 2'b01);
      bus.req = 2'b00;
      tick();
      tick();
      check_eq("mr_next_done", bus.done, 2'b01);
      tick();

      // Timeout: PREADY never high, req dropped after SETUP (rr_ptr=1)
      set_cmd(1, 1'b0, 33'h40, 32'h0, 4'h0);
      bus.send_r_out = 33'h1234;
      bus.PREADY = 1'b0;
      bus.req = 2'b10;
      tick();
      check_eq("to_gnt", bus.gnt, 2'b10);
      bus.req = 2'b00;
      tick();
      for (int i = 0; i < TIMEOUT; i++) begin
         check_eq("to_transfer", bus.transfer, 1);
         tick();
      end
      check_eq("to_done", bus.done, 2'b10);
      check_eq("to_err", bus.rsp_err, 1);
      check_eq("to_transfer_off", bus.transfer, 0);
      check_eq("to_rdata_held", bus.rsp_rdata, 0);
      tick();

      // Slave error, then a clean read clears rsp_err (rr_ptr=0)
      bus.PREADY = 1'b1;
      bus.PSLVERR = 1'b1;
      bus.send_r_out = 33'hDEAD_BEEF;
      set_cmd(0, 1'b0, 33'h0, 32'h0, 4'h0);
      bus.req = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      tick();
      check_eq("se_done", bus.done, 2'b01);
      check_eq("se_err", bus.rsp_err, 1);
      check_eq("se_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      tick();
      bus.PSLVERR = 1'b0;
      bus.send_r_out = 33'h55;
      set_cmd(1, 1'b0, 33'h4, 32'h0, 4'h0);
      bus.req = 2'b10;
      tick();
      bus.req = 2'b00;
      tick();
      tick();
      check_eq("ok_done", bus.done, 2'b10);
      check_eq("ok_err", bus.rsp_err, 0);
      check_eq("ok_rdata", bus.rsp_rdata, 32'h55);
      tick();
      check_eq("ok_rdata_held", bus.rsp_rdata, 32'h55);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
